// File: rtl/fml_burst_writer.sv
// fml_burst_writer: packs a 64-bit stream into 4-beat FML write bursts.
// Define FML_BURST_WRITER_STATS_EN to build the request stall counter.
module fml_burst_writer #(
  parameter int fml_depth = 26,
  parameter int cnt_width = 16
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [fml_depth-1:0] base_adr,
  input  logic [cnt_width-1:0] nbursts,
  output logic                 busy,
  output logic                 done,
  input  logic [63:0]          st_data,
  input  logic [7:0]           st_sel,
  input  logic                 st_valid,
  output logic                 st_ready,
  output logic [fml_depth-1:0] fml_adr,
  output logic                 fml_stb,
  output logic                 fml_we,
  input  logic                 fml_ack,
  output logic [7:0]           fml_sel,
  output logic [63:0]          fml_do,
  output logic [31:0]          stall_cnt
);

  localparam int AW = cnt_width + 2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    REQ,
    DATA
  } state_e;

  state_e               state_q, state_d;
  logic [fml_depth-1:0] adr_q, adr_d;
  logic [cnt_width-1:0] nb_q, nb_d;
  logic [cnt_width-1:0] bdone_q, bdone_d;
  logic [AW-1:0]        acc_q, acc_d;
  logic [AW-1:0]        acc_max;
  logic                 abort_q, abort_d;
  logic [1:0]           full_q, full_d;
  logic                 wbank_q, wbank_d;
  logic                 rbank_q, rbank_d;
  logic [1:0]           widx_q, widx_d;
  logic [1:0]           beat_q, beat_d;
  logic [63:0]          do_q, do_d;
  logic [7:0]           sel_q, sel_d;
  logic [71:0]          mem_q [2][4];
  logic                 accept;
  logic                 done_c;
  logic                 unused_lo;

  assign unused_lo = ^base_adr[4:0];
  assign acc_max   = {nb_q, 2'b00};
  assign busy      = (state_q != IDLE) & ~done_c;
  assign done      = done_c;
  assign st_ready  = busy & ~abort_q & ~full_q[wbank_q]
                   & (acc_q < acc_max);
  assign accept    = st_valid & st_ready;
  assign fml_adr   = adr_q;
  assign fml_we    = 1'b1;
  assign fml_do    = do_q;
  assign fml_sel   = sel_q;

  always_ff @(posedge sys_clk) begin
    if (accept) begin
      mem_q[wbank_q][widx_q] <= {st_sel, st_data};
    end
  end

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    nb_d    = nb_q;
    bdone_d = bdone_q;
    acc_d   = acc_q;
    abort_d = abort_q | abort;
    full_d  = full_q;
    wbank_d = wbank_q;
    rbank_d = rbank_q;
    widx_d  = widx_q;
    beat_d  = beat_q;
    do_d    = '0;
    sel_d   = '0;
    done_c  = 1'b0;
    fml_stb = 1'b0;
    if (accept) begin
      widx_d = widx_q + 2'd1;
      acc_d  = acc_q + AW'(1);
      if (widx_q == 2'd3) begin
        full_d[wbank_q] = 1'b1;
        wbank_d         = ~wbank_q;
      end
    end
    unique case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (start) begin
          adr_d   = {base_adr[fml_depth-1:5], 5'b0};
          nb_d    = nbursts;
          bdone_d = '0;
          acc_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (full_q[rbank_q] && !abort_q) begin
          state_d = REQ;
        end else if (abort_q || bdone_q == nb_q) begin
          // Pending or partial banks are dropped on the way out.
          done_c  = 1'b1;
          state_d = IDLE;
          full_d  = '0;
          widx_d  = '0;
          wbank_d = 1'b0;
          rbank_d = 1'b0;
        end
      end
      REQ: begin
        fml_stb = 1'b1;
        if (fml_ack) begin
          state_d        = DATA;
          beat_d         = '0;
          {sel_d, do_d}  = mem_q[rbank_q][0];
        end
      end
      DATA: begin
        beat_d = beat_q + 2'd1;
        if (beat_q != 2'd3) begin
          {sel_d, do_d} = mem_q[rbank_q][beat_q + 2'd1];
        end else begin
          full_d[rbank_q] = 1'b0;
          rbank_d         = ~rbank_q;
          adr_d           = adr_q + fml_depth'(32);
          bdone_d         = bdone_q + cnt_width'(1);
          // Skip WAIT when the other bank is already queued.
          if (full_q[~rbank_q] && !abort_q && !abort) begin
            state_d = REQ;
          end else begin
            state_d = WAIT;
          end
        end
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      adr_q   <= '0;
      nb_q    <= '0;
      bdone_q <= '0;
      acc_q   <= '0;
      abort_q <= 1'b0;
      full_q  <= '0;
      wbank_q <= 1'b0;
      rbank_q <= 1'b0;
      widx_q  <= '0;
      beat_q  <= '0;
      do_q    <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      nb_q    <= nb_d;
      bdone_q <= bdone_d;
      acc_q   <= acc_d;
      abort_q <= abort_d;
      full_q  <= full_d;
      wbank_q <= wbank_d;
      rbank_q <= rbank_d;
      widx_q  <= widx_d;
      beat_q  <= beat_d;
      do_q    <= do_d;
      sel_q   <= sel_d;
    end
  end

`ifdef FML_BURST_WRITER_STATS_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == IDLE && start) begin
      stall_d = '0;
    end else if (fml_stb && !fml_ack && stall_q != 32'hFFFF_FFFF) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fml_burst_writer.sv
// tb_fml_burst_writer: directed bench with an FML ack responder
// and stream feeder driven from one linear sequence.
module tb_fml_burst_writer;

  localparam int FD = 26;
  localparam int CW = 16;
`ifdef FML_BURST_WRITER_STATS_EN
  localparam logic [31:0] ST_BASIC = 32'd6;
  localparam logic [31:0] ST_BP    = 32'd20;
`else
  localparam logic [31:0] ST_BASIC = 32'd0;
  localparam logic [31:0] ST_BP    = 32'd0;
`endif

  logic          sys_clk   = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          start     = 1'b0;
  logic          abort     = 1'b0;
  logic [FD-1:0] base_adr  = '0;
  logic [CW-1:0] nbursts   = '0;
  logic          busy;
  logic          done;
  logic [63:0]   st_data   = '0;
  logic [7:0]    st_sel    = '0;
  logic          st_valid  = 1'b0;
  logic          st_ready;
  logic [FD-1:0] fml_adr;
  logic          fml_stb;
  logic          fml_we;
  logic          fml_ack   = 1'b0;
  logic [7:0]    fml_sel;
  logic [63:0]   fml_do;
  logic [31:0]   stall_cnt;

  int checks = 0;
  int errors = 0;

  logic [71:0]   tx_q[$];
  logic [71:0]   acc_q[$];
  logic [71:0]   cap_q[$];
  logic [FD-1:0] adr_log[$];
  int cap_left, stb_cnt, nstb, ndone, stb_cyc;
  int ready_seen, acc_at_ack1;
  int lat_first = 3;
  int lat_rest  = 3;
  int n;

  fml_burst_writer #(
    .fml_depth(FD),
    .cnt_width(CW)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .start    (start),
    .abort    (abort),
    .base_adr (base_adr),
    .nbursts  (nbursts),
    .busy     (busy),
    .done     (done),
    .st_data  (st_data),
    .st_sel   (st_sel),
    .st_valid (st_valid),
    .st_ready (st_ready),
    .fml_adr  (fml_adr),
    .fml_stb  (fml_stb),
    .fml_we   (fml_we),
    .fml_ack  (fml_ack),
    .fml_sel  (fml_sel),
    .fml_do   (fml_do),
    .stall_cnt(stall_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag,
                     input logic [143:0] obs,
                     input logic [143:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] wd(input int t, input int i);
    logic [7:0]  s;
    logic [63:0] d;
    s = 8'hFF ^ 8'(i * 16 + t);
    d = {16'hC0DE, 8'(t), 8'h00, 32'(i)};
    return {s, d};
  endfunction

  task automatic clr();
    tx_q.delete();
    acc_q.delete();
    cap_q.delete();
    adr_log.delete();
    cap_left    = 0;
    stb_cnt     = 0;
    nstb        = 0;
    ndone       = 0;
    stb_cyc     = 0;
    ready_seen  = 0;
    acc_at_ack1 = -1;
  endtask

  // One clock: observe at negedge, then drive for the next posedge.
  task automatic tick();
    @(negedge sys_clk);
    if (fml_ack) cap_left = 4;
    fml_ack = 1'b0;
    if (cap_left > 0) begin
      cap_q.push_back({fml_sel, fml_do});
      cap_left--;
    end
    if (done) ndone++;
    if (st_ready) ready_seen++;
    if (fml_stb) begin
      stb_cyc++;
      if (stb_cnt == ((nstb == 0) ? lat_first : lat_rest)) begin
        fml_ack = 1'b1;
        adr_log.push_back(fml_adr);
        if (nstb == 0) acc_at_ack1 = acc_q.size();
        nstb++;
        stb_cnt = 0;
      end else begin
        stb_cnt++;
      end
    end
    st_valid = 1'b0;
    if (tx_q.size() > 0) begin
      st_valid = 1'b1;
      {st_sel, st_data} = tx_q[0];
      if (st_ready) acc_q.push_back(tx_q.pop_front());
    end
  endtask

  task automatic go(input logic [FD-1:0] b, input logic [CW-1:0] nb);
    base_adr = b;
    nbursts  = nb;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int k;
    k = 0;
    while (ndone == 0 && k < budget) begin
      tick();
      k++;
    end
    chk(tag, ndone != 0, 1'b1);
  endtask

  task automatic chk_beats(input string tag, input int t, input int cnt);
    chk({tag, "_nbeats"}, cap_q.size(), cnt);
    for (int k = 0; k < cnt; k++) begin
      chk({tag, "_beat"}, cap_q[k], wd(t, k));
    end
  endtask

  initial begin
    clr();
    tick();
    tick();
    chk("reset_outs",
        {busy, done, st_ready, fml_stb, fml_adr,
         fml_sel, fml_do, stall_cnt}, '0);
    chk("we_const", fml_we, 1'b1);
    sys_rst_n = 1'b1;
    tick();

    // Zero bursts: done on the cycle after start, no traffic.
    go(26'h40, 16'd0);
    chk("nb0_done", done, 1'b1);
    chk("nb0_busy", busy, 1'b0);
    repeat (3) tick();
    chk("nb0_ndone", ndone, 1);
    chk("nb0_stb", stb_cyc, 0);
    chk("nb0_ready", ready_seen, 0);

    // Basic two-burst transfer, ack 3 cycles after stb.
    clr();
    lat_first = 3;
    lat_rest  = 3;
    for (int i = 0; i < 8; i++) tx_q.push_back(wd(1, i));
    go(26'h1000, 16'd2);
    wait_done(300, "basic_timeout");
    repeat (3) tick();
    chk("basic_nadr", adr_log.size(), 2);
    chk("basic_adr0", adr_log[0], 26'h1000);
    chk("basic_adr1", adr_log[1], 26'h1020);
    chk_beats("basic", 1, 8);
    chk("basic_ndone", ndone, 1);
    chk("basic_busy", busy, 1'b0);
    chk("basic_stall", stall_cnt, ST_BASIC);

    // Backpressure: first ack held off 20 cycles.
    clr();
    lat_first = 20;
    lat_rest  = 0;
    for (int i = 0; i < 12; i++) tx_q.push_back(wd(2, i));
    go(26'h2000, 16'd3);
    wait_done(400, "bp_timeout");
    repeat (3) tick();
    chk("bp_acc_at_ack", acc_at_ack1, 8);
    chk("bp_nadr", adr_log.size(), 3);
    chk("bp_adr2", adr_log[2], 26'h2040);
    chk_beats("bp", 2, 12);
    chk("bp_stall", stall_cnt, ST_BP);
    chk("bp_ndone", ndone, 1);

    // Abort during REQ of burst 0 after 6 words.
    clr();
    lat_first = 3;
    lat_rest  = 3;
    for (int i = 0; i < 6; i++) tx_q.push_back(wd(3, i));
    go(26'h3000, 16'd4);
    n = 0;
    while (!(fml_stb && acc_q.size() == 6) && n < 50) begin
      tick();
      n++;
    end
    chk("ab_reach_req", fml_stb && acc_q.size() == 6, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_done(200, "ab_timeout");
    repeat (4) tick();
    chk("ab_nstb", nstb, 1);
    chk_beats("ab", 3, 4);
    chk("ab_ndone", ndone, 1);
    chk("ab_busy", busy, 1'b0);
    chk("ab_ready", st_ready, 1'b0);

    // Address wrap; low base bits ignored.
    clr();
    for (int i = 0; i < 8; i++) tx_q.push_back(wd(4, i));
    go(26'h3FFFFEB, 16'd2);
    wait_done(300, "wrap_timeout");
    repeat (3) tick();
    chk("wrap_adr0", adr_log[0], 26'h3FFFFE0);
    chk("wrap_adr1", adr_log[1], 26'h0000000);
    chk_beats("wrap", 4, 8);

    // Asynchronous reset during DATA beat 2.
    clr();
    for (int i = 0; i < 8; i++) tx_q.push_back(wd(5, i));
    go(26'h5000, 16'd2);
    n = 0;
    while (cap_q.size() < 3 && n < 100) begin
      tick();
      n++;
    end
    chk("rst_reach", cap_q.size(), 3);
    chk("rst_beat2", cap_q[2], wd(5, 2));
    #2 sys_rst_n = 1'b0;
    #1 chk("rst_async",
           {busy, done, st_ready, fml_stb, fml_adr,
            fml_sel, fml_do, stall_cnt}, '0);
    tick();
    tick();
    clr();
    sys_rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) tx_q.push_back(wd(6, i));
    go(26'h6000, 16'd1);
    wait_done(200, "post_rst_timeout");
    repeat (3) tick();
    chk("post_rst_nadr", adr_log.size(), 1);
    chk("post_rst_adr", adr_log[0], 26'h6000);
    chk_beats("post_rst", 6, 4);
    chk("post_rst_ndone", ndone, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
